// File: rtl/debug_trace_checker_pkg.sv
// Shared types for the writeback-trace checker.
//   addr_t / regid_t / word_t : trace field types
//   chk_state_t               : checker verdict (RUN / PASS / FAIL)
//   trace_ent_t               : one register-writing commit {pc, wnum, wdata}
package debug_trace_checker_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [4:0]  regid_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10
  } chk_state_t;

  typedef struct packed {
    addr_t  pc;
    regid_t wnum;
    word_t  wdata;
  } trace_ent_t;

endpackage

// File: rtl/debug_trace_checker_trace_fifo.sv
// Synchronous FIFO of trace entries.
//   i_clk, i_rst      : clock, async active-high reset (clears pointers only)
//   i_push, i_din     : write an entry (caller guarantees not full unless popping)
//   i_pop, o_head     : head entry, dropped on i_pop (caller guarantees not empty)
//   o_full, o_empty   : occupancy flags from the registered pointers
// The head is read straight from the registered read pointer, so an entry
// written this cycle is not visible until the next one.
module debug_trace_checker_trace_fifo
  import debug_trace_checker_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  trace_ent_t i_din,
  input  logic       i_pop,
  output trace_ent_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  trace_ent_t    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is readable until written.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/debug_trace_checker.sv
// Writeback-trace self-checker.
// Buffers register-writing commits from the debug_wb_* trace and compares them
// in order with a golden trace on a valid/ready port. Latches the first
// mismatch (or buffer overrun) and reports PASS once END_PC compares equal.
//   clk, reset             : clock, async active-high reset
//   debug_wb_*             : DUT trace, pc==0 means no commit this cycle
//   ref_valid/ref_ready    : golden handshake, ref_ready==1 consumes ref_*
//   ref_pc/wnum/wdata      : golden entry
//   state_o                : 00 RUN, 01 PASS, 10 FAIL
//   overflow               : FAIL was caused by a buffer overrun
//   err_* / exp_*          : DUT / golden entry at the first failure
//   commit_cnt, cmp_cnt    : saturating commit and good-compare counters
module debug_trace_checker
  import debug_trace_checker_pkg::*;
#(
  parameter int    DEPTH  = 16,
  parameter addr_t END_PC = 32'hbfc0_0100,
  parameter int    CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      debug_wb_pc,
  input  logic [3:0]       debug_wb_rf_wen,
  input  logic [4:0]       debug_wb_rf_wnum,
  input  logic [31:0]      debug_wb_rf_wdata,
  input  logic             ref_valid,
  output logic             ref_ready,
  input  logic [31:0]      ref_pc,
  input  logic [4:0]       ref_wnum,
  input  logic [31:0]      ref_wdata,
  output logic [1:0]       state_o,
  output logic             overflow,
  output logic [31:0]      err_pc,
  output logic [4:0]       err_wnum,
  output logic [31:0]      err_wdata,
  output logic [31:0]      exp_pc,
  output logic [4:0]       exp_wnum,
  output logic [31:0]      exp_wdata,
  output logic [CNT_W-1:0] commit_cnt,
  output logic [CNT_W-1:0] cmp_cnt
);

  chk_state_t       r_state;
  logic             r_overflow;
  trace_ent_t       r_err;
  trace_ent_t       r_exp;
  logic [CNT_W-1:0] r_commit_cnt;
  logic [CNT_W-1:0] r_cmp_cnt;

  trace_ent_t w_in;
  trace_ent_t w_ref;
  trace_ent_t w_head;
  logic       w_run;
  logic       w_wr;
  logic       w_fire;
  logic       w_ovf;
  logic       w_push;
  logic       w_full;
  logic       w_empty;
  logic       w_match;

  assign w_in  = '{pc: debug_wb_pc, wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};
  assign w_ref = '{pc: ref_pc, wnum: ref_wnum, wdata: ref_wdata};

  assign w_run   = (r_state == ST_RUN);
  // Only real register writes are checked; r0 writes and bubbles are ignored.
  assign w_wr    = (debug_wb_pc != '0) && (|debug_wb_rf_wen) && (debug_wb_rf_wnum != '0);
  assign w_fire  = w_run && !w_empty && ref_valid;
  // A same-cycle pop frees the slot, so push-on-full is only an overrun without it.
  assign w_ovf   = w_run && w_wr && w_full && !w_fire;
  assign w_push  = w_run && w_wr && !w_ovf;
  assign w_match = (w_head == w_ref);

  debug_trace_checker_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_din   (w_in),
    .i_pop   (w_fire),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_overflow   <= 1'b0;
      r_err        <= '0;
      r_exp        <= '0;
      r_commit_cnt <= '0;
      r_cmp_cnt    <= '0;
    end else begin
      // Commits are counted in every state, stopping at all-ones.
      if (debug_wb_pc != '0)
        r_commit_cnt <= r_commit_cnt + {{(CNT_W-1){1'b0}}, ~&r_commit_cnt};

      if (w_ovf) begin
        r_state    <= ST_FAIL;
        r_overflow <= 1'b1;
        r_err      <= w_in;
        r_exp      <= '0;
      end else if (w_fire) begin
        if (w_match) begin
          r_cmp_cnt <= r_cmp_cnt + {{(CNT_W-1){1'b0}}, ~&r_cmp_cnt};
          if (w_head.pc == END_PC) r_state <= ST_PASS;
        end else begin
          r_state <= ST_FAIL;
          r_err   <= w_head;
          r_exp   <= w_ref;
        end
      end
    end
  end

  assign ref_ready  = w_fire;
  assign state_o    = r_state;
  assign overflow   = r_overflow;
  assign err_pc     = r_err.pc;
  assign err_wnum   = r_err.wnum;
  assign err_wdata  = r_err.wdata;
  assign exp_pc     = r_exp.pc;
  assign exp_wnum   = r_exp.wnum;
  assign exp_wdata  = r_exp.wdata;
  assign commit_cnt = r_commit_cnt;
  assign cmp_cnt    = r_cmp_cnt;

endmodule

// File: tb/tb_debug_trace_checker.sv
// Bench for debug_trace_checker: a vector table for the basic PASS flows,
// hand sequences for mismatch / overrun / full push+pop / async reset, and
// randomized traffic checked against a queue-based reference model.
module tb_debug_trace_checker;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] END_PC = 32'hbfc0_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] debug_wb_pc = '0;
  logic [3:0]  debug_wb_rf_wen = '0;
  logic [4:0]  debug_wb_rf_wnum = '0;
  logic [31:0] debug_wb_rf_wdata = '0;
  logic        ref_valid = 1'b0;
  logic        ref_ready;
  logic [31:0] ref_pc = '0;
  logic [4:0]  ref_wnum = '0;
  logic [31:0] ref_wdata = '0;
  logic [1:0]  state_o;
  logic        overflow;
  logic [31:0] err_pc, err_wdata, exp_pc, exp_wdata;
  logic [4:0]  err_wnum, exp_wnum;
  logic [31:0] commit_cnt, cmp_cnt;

  debug_trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .ref_valid(ref_valid), .ref_ready(ref_ready),
    .ref_pc(ref_pc), .ref_wnum(ref_wnum), .ref_wdata(ref_wdata),
    .state_o(state_o), .overflow(overflow),
    .err_pc(err_pc), .err_wnum(err_wnum), .err_wdata(err_wdata),
    .exp_pc(exp_pc), .exp_wnum(exp_wnum), .exp_wdata(exp_wdata),
    .commit_cnt(commit_cnt), .cmp_cnt(cmp_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // 0 RUN, 1 PASS, 2 FAIL
  int          m_state;
  int unsigned m_commit, m_cmp;
  bit          m_ovf;
  ent_t        m_err, m_exp;
  ent_t        mq[$];

  task automatic model_reset();
    m_state = 0; m_commit = 0; m_cmp = 0; m_ovf = 0;
    m_err = '0; m_exp = '0;
    mq.delete();
  endtask

  function automatic bit model_fire(input bit rv);
    return (m_state == 0) && (mq.size() > 0) && rv;
  endfunction

  task automatic model_step(input ent_t d, input logic [3:0] wen, input bit rv,
                            input ent_t r, output bit pushed, output bit fired);
    bit wr;
    ent_t h;
    wr = (d.pc != 0) && (wen != 0) && (d.wnum != 0);
    fired = model_fire(rv);
    pushed = 0;
    if (d.pc != 0) m_commit++;
    if (m_state == 0) begin
      if (wr && mq.size() == DEPTH && !fired) begin
        m_state = 2; m_ovf = 1; m_err = d; m_exp = '0;
      end else begin
        if (fired) begin
          h = mq.pop_front();
          if (h == r) begin
            m_cmp++;
            if (h.pc == END_PC) m_state = 1;
          end else begin
            m_state = 2; m_err = h; m_exp = r;
          end
        end
        if (wr) begin
          mq.push_back(d);
          pushed = 1;
        end
      end
    end
  endtask

  // ---------------- drive helpers ----------------
  localparam ent_t NONE = '0;

  task automatic set_in(input ent_t d, input logic [3:0] wen, input bit rv, input ent_t r);
    debug_wb_pc = d.pc; debug_wb_rf_wnum = d.wnum; debug_wb_rf_wdata = d.wdata;
    debug_wb_rf_wen = wen;
    ref_valid = rv; ref_pc = r.pc; ref_wnum = r.wnum; ref_wdata = r.wdata;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".state"}, state_o, 0);
    chk({tag, ".ready"}, ref_ready, 0);
    chk({tag, ".commit"}, commit_cnt, 0);
    chk({tag, ".cmp"}, cmp_cnt, 0);
    chk({tag, ".ovf"}, overflow, 0);
    chk({tag, ".err_pc"}, err_pc, 0);
    chk({tag, ".err_wdata"}, err_wdata, 0);
    chk({tag, ".exp_pc"}, exp_pc, 0);
  endtask

  task automatic do_reset();
    set_in(NONE, 4'h0, 1'b1, NONE);
    reset = 1'b1;
    #1;
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    ent_t        d;
    logic [3:0]  wen;
    bit          rv;
    ent_t        r;
    bit          rdy;
    logic [1:0]  st;
    int unsigned commit;
    int unsigned cmp;
  } vec_t;

  localparam ent_t E0   = '{32'hbfc0_0000, 5'd2, 32'd1};
  localparam ent_t E1   = '{32'hbfc0_0004, 5'd3, 32'd2};
  localparam ent_t E2   = '{32'hbfc0_0100, 5'd4, 32'd3};
  localparam ent_t WZ   = '{32'h0000_1234, 5'd0, 32'h55};
  localparam ent_t NW   = '{32'hbfc0_0050, 5'd5, 32'h77};
  localparam ent_t LATE = '{32'hbfc0_0200, 5'd5, 32'h9};

  vec_t tbl[15];

  task automatic run_rows(input int lo, input int hi, input bit honor_rst);
    for (int i = lo; i <= hi; i++) begin
      if (honor_rst && tbl[i].rst) do_reset();
      set_in(tbl[i].d, tbl[i].wen, tbl[i].rv, tbl[i].r);
      @(negedge clk);
      chk($sformatf("tbl%0d.ready", i), ref_ready, tbl[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.state", i), state_o, tbl[i].st);
      chk($sformatf("tbl%0d.commit", i), commit_cnt, tbl[i].commit);
      chk($sformatf("tbl%0d.cmp", i), cmp_cnt, tbl[i].cmp);
    end
  endtask

  // One clock with inputs applied, ready checked at negedge, registers after the edge.
  task automatic cyc(input string tag, input ent_t d, input logic [3:0] wen,
                     input bit rv, input ent_t r, input bit exp_rdy);
    set_in(d, wen, rv, r);
    @(negedge clk);
    chk({tag, ".ready"}, ref_ready, exp_rdy);
    @(posedge clk); #1;
  endtask

  // ---------------- randomized run ----------------
  task automatic rand_run(input int ncyc, input bit noisy);
    ent_t gq[$];
    ent_t d, r, g;
    logic [3:0] wen;
    bit rv, pushed, fired;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      d.pc    = ($urandom_range(0, 4) == 0) ? 32'h0
              : 32'hbfc0_0000 + 4 * $urandom_range(0, noisy ? 64 : 63);
      d.wnum  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d.wdata = $urandom;
      wen     = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (noisy) rv = $urandom_range(0, 1) == 1;
      else       rv = ($urandom_range(0, 2) != 0) || (mq.size() >= DEPTH - 1);
      r = (gq.size() > 0) ? gq[0] : ent_t'({$urandom, 5'($urandom), $urandom});
      set_in(d, wen, rv, r);
      @(negedge clk);
      chk("rand.ready", ref_ready, model_fire(rv));
      @(posedge clk);
      model_step(d, wen, rv, r, pushed, fired);
      if (fired) void'(gq.pop_front());
      if (pushed) begin
        g = d;
        if (noisy && $urandom_range(0, 59) == 0) g.wdata = g.wdata ^ 32'h1;
        gq.push_back(g);
      end
      #1;
      chk("rand.state", state_o, m_state);
      chk("rand.commit", commit_cnt, m_commit);
      chk("rand.cmp", cmp_cnt, m_cmp);
      chk("rand.ovf", overflow, m_ovf);
      chk("rand.err_pc", err_pc, m_err.pc);
      chk("rand.err_wnum", err_wnum, m_err.wnum);
      chk("rand.err_wdata", err_wdata, m_err.wdata);
      chk("rand.exp_pc", exp_pc, m_exp.pc);
      chk("rand.exp_wnum", exp_wnum, m_exp.wnum);
      chk("rand.exp_wdata", exp_wdata, m_exp.wdata);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t g, dd;
    // rst  d     wen   rv r   rdy st    commit cmp
    tbl[0]  = '{1, E0,   4'hf, 1, E0, 0, 2'd0, 1, 0};
    tbl[1]  = '{0, E1,   4'hf, 1, E0, 1, 2'd0, 2, 1};
    tbl[2]  = '{0, E2,   4'hf, 1, E1, 1, 2'd0, 3, 2};
    tbl[3]  = '{0, NONE, 4'h0, 1, E2, 1, 2'd1, 3, 3};
    tbl[4]  = '{0, NONE, 4'h0, 1, E2, 0, 2'd1, 3, 3};
    tbl[5]  = '{1, NONE, 4'h0, 1, E0, 0, 2'd0, 0, 0};
    tbl[6]  = '{0, E0,   4'hf, 1, E0, 0, 2'd0, 1, 0};
    tbl[7]  = '{0, WZ,   4'hf, 1, E0, 1, 2'd0, 2, 1};
    tbl[8]  = '{0, NONE, 4'h0, 1, E1, 0, 2'd0, 2, 1};
    tbl[9]  = '{0, E1,   4'hf, 1, E1, 0, 2'd0, 3, 1};
    tbl[10] = '{0, NONE, 4'h0, 1, E1, 1, 2'd0, 3, 2};
    tbl[11] = '{0, NW,   4'h0, 1, E2, 0, 2'd0, 4, 2};
    tbl[12] = '{0, E2,   4'hf, 1, E2, 0, 2'd0, 5, 2};
    tbl[13] = '{0, NONE, 4'h0, 1, E2, 1, 2'd1, 5, 3};
    tbl[14] = '{0, LATE, 4'hf, 1, E2, 0, 2'd1, 6, 3};

    // Basic PASS flow, then the same with bubbles and r0 writes interleaved.
    run_rows(0, 14, 1);

    // Data mismatch: FAIL one cycle after both sides are present, then frozen.
    do_reset();
    g  = '{32'hbfc0_0004, 5'd3, 32'd2};
    dd = '{32'hbfc0_0004, 5'd3, 32'd3};
    cyc("mm0", dd, 4'hf, 1, g, 0);
    chk("mm0.state", state_o, 0);
    cyc("mm1", NONE, 4'h0, 1, g, 1);
    chk("mm1.state", state_o, 2);
    chk("mm1.err_pc", err_pc, 32'hbfc0_0004);
    chk("mm1.err_wdata", err_wdata, 3);
    chk("mm1.exp_wdata", exp_wdata, 2);
    chk("mm1.exp_wnum", exp_wnum, 3);
    chk("mm1.cmp", cmp_cnt, 0);
    chk("mm1.ovf", overflow, 0);
    for (int k = 0; k < 3; k++) begin
      cyc("mmhold", dd, 4'hf, 1, g, 0);
      chk("mmhold.state", state_o, 2);
      chk("mmhold.err_wdata", err_wdata, 3);
      chk("mmhold.commit", commit_cnt, 32'(2 + k));
    end

    // Overrun: DEPTH+1 pushes with the golden side stalled.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      cyc("ovf", '{32'h1000 + 32'(4 * i), 5'd1, 32'(i)}, 4'h1, 0, NONE, 0);
      if (i == DEPTH - 1) begin
        chk("ovf.full_state", state_o, 0);
        chk("ovf.full_flag", overflow, 0);
      end
    end
    chk("ovf.state", state_o, 2);
    chk("ovf.flag", overflow, 1);
    chk("ovf.err_pc", err_pc, 32'h1040);
    chk("ovf.exp_pc", exp_pc, 0);
    chk("ovf.exp_wdata", exp_wdata, 0);
    chk("ovf.commit", commit_cnt, DEPTH + 1);

    // Full buffer with push and pop together: no overrun, still full after.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cyc("full", '{32'h2000 + 32'(4 * i), 5'd2, 32'(100 + i)}, 4'hf, 0, NONE, 0);
    cyc("fullpp", '{32'h2000 + 32'(4 * DEPTH), 5'd2, 32'(100 + DEPTH)}, 4'hf, 1,
        '{32'h2000, 5'd2, 32'd100}, 1);
    chk("fullpp.state", state_o, 0);
    chk("fullpp.ovf", overflow, 0);
    chk("fullpp.cmp", cmp_cnt, 1);
    cyc("fullstill", '{32'h3000, 5'd2, 32'd7}, 4'hf, 0, NONE, 0);
    chk("fullstill.ovf", overflow, 1);
    chk("fullstill.err_pc", err_pc, 32'h3000);

    // Wrap the pointers several times with stalls, then noisy traffic.
    rand_run(400, 0);
    rand_run(600, 1);

    // Async reset in the middle of a compare with 5 entries buffered.
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc("pre", '{32'h4000 + 32'(4 * i), 5'd6, 32'(i)}, 4'hf, 0, NONE, 0);
    cyc("pre.fire", NONE, 4'h0, 1, '{32'h4000, 5'd6, 32'd0}, 1);
    chk("pre.cmp", cmp_cnt, 1);
    set_in(NONE, 4'h0, 1, '{32'h4004, 5'd6, 32'd1});
    @(negedge clk);
    chk("mid.ready", ref_ready, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    // Stale entries must not reappear: a clean rerun passes.
    run_rows(0, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
